// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: fetch PC sequencer arbitrating exception, eret and branch redirects against stall.
// Optional macro BRANCH_FLUSH_EN: branch redirects also flush IF/ID (no delay slot).
module pc_redirect_ctrl #(
   parameter logic [31:0] INIT_PC   = 32'h0000_3000,
   parameter logic [31:0] EXC_PC    = 32'h0000_4180,
   parameter int          ERET_WAIT = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] F_pc_i,
   input  logic        block_i,
   input  logic        Req_i,
   input  logic [31:0] EPC_i,
   input  logic        D_eret_i,
   input  logic        br_valid_i,
   input  logic [31:0] br_target_i,
   output logic [31:0] nextPC_o,
   output logic        pc_en_o,
   output logic        F_flush_o,
   output logic        redir_pend_o
);
`ifdef BRANCH_FLUSH_EN
   localparam logic BR_FLUSH = 1'b1;
`else
   localparam logic BR_FLUSH = 1'b0;
`endif
   localparam int CW = (ERET_WAIT > 1) ? $clog2(ERET_WAIT) : 1;

   typedef enum logic [1:0] {RUN, HOLD, EWAIT} state_t;

   state_t          state_q, state_d;
   logic [31:0]     pend_tgt_q, pend_tgt_d;
   logic            pend_eret_q, pend_eret_d;
   logic [CW-1:0]   ecnt_q, ecnt_d;
   logic [31:0]     npc, br_tgt;
   logic            en, fl, rp, do_eret, do_br;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         pend_tgt_q  <= '0;
         pend_eret_q <= 1'b0;
         ecnt_q      <= '0;
      end else begin
         state_q     <= state_d;
         pend_tgt_q  <= pend_tgt_d;
         pend_eret_q <= pend_eret_d;
         ecnt_q      <= ecnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pend_tgt_d  = pend_tgt_q;
      pend_eret_d = pend_eret_q;
      ecnt_d      = ecnt_q;
      npc         = F_pc_i;
      en          = 1'b0;
      fl          = 1'b0;
      rp          = 1'b0;
      do_eret     = 1'b0;
      do_br       = 1'b0;
      br_tgt      = br_target_i;
      if (Req_i) begin
         npc         = EXC_PC;
         en          = 1'b1;
         fl          = 1'b1;
         pend_tgt_d  = '0;
         pend_eret_d = 1'b0;
         ecnt_d      = '0;
         state_d     = RUN;
      end else begin
         case (state_q)
            RUN: begin
               if (block_i) begin
                  pend_eret_d = D_eret_i;
                  pend_tgt_d  = br_target_i;
                  state_d     = (D_eret_i || br_valid_i) ? HOLD : RUN;
               end else begin
                  do_eret = D_eret_i;
                  do_br   = br_valid_i;
                  npc     = F_pc_i + 32'd4;
                  en      = 1'b1;
               end
            end
            HOLD: begin
               rp = 1'b1;
               if (block_i) begin
                  pend_eret_d = pend_eret_q | D_eret_i;
                  pend_tgt_d  = (br_valid_i && !pend_eret_q && !D_eret_i) ? br_target_i : pend_tgt_q;
               end else begin
                  do_eret     = pend_eret_q;
                  do_br       = !pend_eret_q;
                  br_tgt      = pend_tgt_q;
                  pend_eret_d = 1'b0;
                  pend_tgt_d  = '0;
                  state_d     = RUN;
               end
            end
            default: begin
               // EPC is sampled only on the final cycle so a late CP0 write is picked up
               if (ecnt_q == '0) begin
                  npc     = EPC_i;
                  en      = 1'b1;
                  fl      = 1'b1;
                  state_d = RUN;
               end else begin
                  ecnt_d = ecnt_q - 1'b1;
               end
            end
         endcase
         if (do_eret) begin
            if (ERET_WAIT == 0) begin
               npc     = EPC_i;
               en      = 1'b1;
               fl      = 1'b1;
               state_d = RUN;
            end else begin
               npc     = F_pc_i;
               en      = 1'b0;
               ecnt_d  = CW'(ERET_WAIT - 1);
               state_d = EWAIT;
            end
         end else if (do_br) begin
            npc     = br_tgt;
            en      = 1'b1;
            fl      = BR_FLUSH;
            state_d = RUN;
         end
      end
   end

   assign nextPC_o     = rst_n ? npc : INIT_PC;
   assign pc_en_o      = rst_n & en;
   assign F_flush_o    = rst_n & fl;
   assign redir_pend_o = rst_n & rp;

endmodule
